// File: rtl/game_round_ctrl.sv
// Round controller for the guessing-number game: sequences comparator submits, counts
// attempts and latches win/lose/hint. Optional per-attempt timeout under `TIMEOUT_EN`.
module game_round_ctrl #(
  parameter int unsigned MAX_TRIES   = 7,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       guess_btn,
  input  logic       eq,
  input  logic       gt,
  input  logic       sm,
  output logic       game_active,
  output logic       cmp_submit,
  output logic [3:0] tries_used,
  output logic [1:0] hint,
  output logic       win,
  output logic       lose,
  output logic       busy,
  output logic       cmp_err,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, PLAY, STROBE, SETTLE, EVAL, WON, LOST} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  if (MAX_TRIES < 1 || MAX_TRIES > 15 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("game_round_ctrl: MAX_TRIES must be 1..15 and TIMEOUT_CYC >= 2");
  end

  state_t     state;
  logic       btn_q;
  logic       btn_rise;
  logic [3:0] tries_nxt;
  logic       res_eq;
  logic       res_one;

  assign btn_rise  = guess_btn & ~btn_q;
  assign tries_nxt = (tries_used < MAX_T) ? tries_used + 4'd1 : MAX_T;
  assign res_eq    = eq & ~gt & ~sm;
  assign res_one   = $onehot({eq, gt, sm});

`ifdef TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] timer;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      game_active <= 1'b0;
      cmp_submit  <= 1'b0;
      tries_used  <= 4'd0;
      hint        <= 2'b00;
      win         <= 1'b0;
      lose        <= 1'b0;
      busy        <= 1'b0;
      cmp_err     <= 1'b0;
`ifdef TIMEOUT_EN
      timer       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      btn_q      <= guess_btn;
      cmp_submit <= 1'b0;
      cmp_err    <= 1'b0;
`ifdef TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      if (start) begin
        state       <= PLAY;
        tries_used  <= 4'd0;
        hint        <= 2'b00;
        win         <= 1'b0;
        lose        <= 1'b0;
        busy        <= 1'b0;
        game_active <= 1'b1;
`ifdef TIMEOUT_EN
        timer       <= '0;
`endif
      end else begin
        case (state)
          PLAY: begin
            if (btn_rise) begin
              state      <= STROBE;
              cmp_submit <= 1'b1;
              busy       <= 1'b1;
`ifdef TIMEOUT_EN
              timer      <= '0;
`endif
            end
`ifdef TIMEOUT_EN
            else if (timer == T_LAST) begin
              // Expiry burns an attempt with no hint, like a wrong guess
              timeout_q  <= 1'b1;
              tries_used <= tries_nxt;
              hint       <= 2'b00;
              timer      <= '0;
              if (tries_nxt == MAX_T) begin
                lose        <= 1'b1;
                game_active <= 1'b0;
                state       <= LOST;
              end
            end else begin
              timer <= timer + TW'(1);
            end
`endif
          end
          STROBE: state <= SETTLE;
          // Comparator captures during SETTLE; its result is stable by EVAL
          SETTLE: state <= EVAL;
          EVAL: begin
            busy <= 1'b0;
`ifdef TIMEOUT_EN
            timer <= '0;
`endif
            if (res_eq) begin
              win         <= 1'b1;
              hint        <= 2'b00;
              game_active <= 1'b0;
              state       <= WON;
            end else if (res_one) begin
              tries_used <= tries_nxt;
              hint       <= gt ? 2'b01 : 2'b10;
              if (tries_nxt == MAX_T) begin
                lose        <= 1'b1;
                game_active <= 1'b0;
                state       <= LOST;
              end else begin
                state <= PLAY;
              end
            end else begin
              cmp_err <= 1'b1;
              state   <= PLAY;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
